// File: rtl/calc_pkg.sv
// Shared calculator constants (core status, keypad commands) and the scheduler state type.
// Pure declarations: no logic, no latency, no flow control.
package calc_pkg;

    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;
    localparam logic [1:0] ST_PRINT = 2'b11;

    localparam logic [3:0] CMD_ADD  = 4'd10;
    localparam logic [3:0] CMD_SUB  = 4'd11;
    localparam logic [3:0] CMD_MUL  = 4'd12;
    localparam logic [3:0] CMD_NOP  = 4'd13;
    localparam logic [3:0] CMD_EQ   = 4'd14;
    localparam logic [3:0] CMD_BKSP = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_ERR       = 3'd4
    } sched_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with flush: push visible in level one cycle later, head is the oldest entry.
// Push is dropped when full and pop when empty; flush overrides both and empties the FIFO.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/calc_cmd_sched.sv
// Queues keypad codes and issues one registered cmd per core READY; key to cmd is two edges.
// key_ready drops when the FIFO is full or after a core error; errors flush until reset.
module calc_cmd_sched
    import calc_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         key_valid,
    input  logic [3:0]                   key_code,
    output logic                         key_ready,
    input  logic [1:0]                   calc_status,
    output logic [3:0]                   cmd,
    output logic                         error,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [7:0]                   issued
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(ACK_TIMEOUT - 1);

    sched_state_t  state, state_nxt;
    logic [TW-1:0] timer;
    logic          timer_clr;
    logic          timer_inc;
    logic          go_err;
    logic          push;
    logic          pop;
    logic          flush;
    logic          full;
    logic          empty;
    logic [3:0]    head;

    assign key_ready = !full && (state != S_ERR);
    assign push      = key_valid && key_ready;
    assign go_err    = (state != S_ERR) && (calc_status == ST_ERR);
    assign flush     = go_err || (state == S_ERR);

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (key_code),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        timer_clr = 1'b0;
        timer_inc = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty && calc_status == ST_READY) begin
                    pop       = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_clr = 1'b1;
                state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (calc_status != ST_READY)
                    state_nxt = S_WAIT_DONE;
                else if (timer == TMR_LAST)
                    state_nxt = S_IDLE;
                else
                    timer_inc = 1'b1;
            end
            S_WAIT_DONE: begin
                if (calc_status == ST_READY) state_nxt = S_IDLE;
            end
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_IDLE;
        endcase
        // A core error wins over everything, including a pop on the same edge.
        if (go_err) begin
            state_nxt = S_ERR;
            pop       = 1'b0;
            timer_clr = 1'b0;
            timer_inc = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= S_IDLE;
            timer  <= '0;
            cmd    <= CMD_NOP;
            error  <= 1'b0;
            issued <= 8'd0;
        end else begin
            state <= state_nxt;
            cmd   <= pop ? head : CMD_NOP;
            if (go_err) error <= 1'b1;
            if (pop) issued <= issued + 8'd1;
            if (timer_clr)
                timer <= '0;
            else if (timer_inc)
                timer <= timer + TW'(1);
        end
    end

endmodule

// File: tb/tb_calc_cmd_sched.sv
// Self-checking bench for calc_cmd_sched: directed vector table, corner sequences and
// randomized traffic compared every cycle against a queue-based reference model.
module tb_calc_cmd_sched;
    import calc_pkg::*;

    localparam int DEPTH = 4;
    localparam int AT    = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          key_valid = 1'b0;
    logic [3:0]    key_code = 4'd0;
    logic [1:0]    calc_status = ST_READY;
    logic          key_ready;
    logic [3:0]    cmd;
    logic          error;
    logic [LW-1:0] level;
    logic [7:0]    issued;

    always #5 clock = ~clock;

    calc_cmd_sched #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (AT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .calc_status (calc_status),
        .cmd         (cmd),
        .error       (error),
        .level       (level),
        .issued      (issued)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pending keys in a queue, a phase tag and a countdown of ack cycles left.
    localparam int P_IDLE = 0, P_ISSUED = 1, P_ACK = 2, P_DONE = 3, P_ERR = 4;
    int mq[$];
    int m_phase = P_IDLE;
    int m_left  = 0;
    int m_err   = 0;
    int m_cmd   = 13;
    int m_iss   = 0;

    task automatic model_edge(input bit rst, input bit kv, input int kc, input int st);
        bit kr;
        if (!rst) begin
            mq.delete();
            m_phase = P_IDLE;
            m_left  = 0;
            m_err   = 0;
            m_cmd   = 13;
            m_iss   = 0;
            return;
        end
        m_cmd = 13;
        if (m_phase == P_ERR) return;
        kr = (mq.size() < DEPTH);
        if (st == 0) begin
            mq.delete();
            m_phase = P_ERR;
            m_err   = 1;
            return;
        end
        case (m_phase)
            P_IDLE: if (mq.size() > 0 && st == 2) begin
                m_cmd = mq.pop_front();
                m_iss++;
                m_phase = P_ISSUED;
            end
            P_ISSUED: begin
                m_phase = P_ACK;
                m_left  = AT;
            end
            P_ACK: begin
                m_left--;
                if (st != 2) m_phase = P_DONE;
                else if (m_left == 0) m_phase = P_IDLE;
            end
            P_DONE: if (st == 2) m_phase = P_IDLE;
            default: ;
        endcase
        if (kv && kr) mq.push_back(kc);
    endtask

    task automatic cyc(input bit rst, input bit kv, input logic [3:0] kc, input logic [1:0] st);
        reset       = rst;
        key_valid   = kv;
        key_code    = kc;
        calc_status = st;
        @(posedge clock);
        model_edge(rst, kv, int'(kc), int'(st));
        #1;
        check("model_cmd",       int'(cmd),       m_cmd);
        check("model_level",     int'(level),     mq.size());
        check("model_key_ready", int'(key_ready), (m_err == 0 && mq.size() < DEPTH) ? 1 : 0);
        check("model_error",     int'(error),     m_err);
        check("model_issued",    int'(issued),    m_iss % 256);
    endtask

    typedef struct {
        bit           rst;
        bit           kv;
        logic [3:0]   kc;
        logic [1:0]   st;
        logic [3:0]   e_cmd;
        int           e_lvl;
        bit           e_kr;
        bit           e_err;
        int           e_iss;
        sched_state_t e_st;
    } vec_t;

    function automatic vec_t mk(input bit rst, input bit kv, input logic [3:0] kc,
                                input logic [1:0] st, input logic [3:0] e_cmd, input int e_lvl,
                                input bit e_kr, input bit e_err, input int e_iss,
                                input sched_state_t e_st);
        vec_t v;
        v.rst = rst; v.kv = kv; v.kc = kc; v.st = st;
        v.e_cmd = e_cmd; v.e_lvl = e_lvl; v.e_kr = e_kr; v.e_err = e_err;
        v.e_iss = e_iss; v.e_st = e_st;
        return v;
    endfunction

    vec_t vt[$];
    int   got[$];
    int   n_iss;
    int   busy_n;
    bit   r_rst;
    bit   r_kv;
    int   r_sel;
    logic [1:0] r_st;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single key through the print path, then a key that times out, then push+pop together.
        vt.push_back(mk(0, 0, 4'd0,  ST_READY, CMD_NOP, 0, 1, 0, 0, S_IDLE));
        vt.push_back(mk(1, 1, 4'd7,  ST_READY, CMD_NOP, 1, 1, 0, 0, S_IDLE));
        vt.push_back(mk(1, 0, 4'd0,  ST_READY, 4'd7,    0, 1, 0, 1, S_ISSUE));
        vt.push_back(mk(1, 0, 4'd0,  ST_PRINT, CMD_NOP, 0, 1, 0, 1, S_WAIT_ACK));
        for (int i = 0; i < 8; i++)
            vt.push_back(mk(1, 0, 4'd0, ST_PRINT, CMD_NOP, 0, 1, 0, 1, S_WAIT_DONE));
        vt.push_back(mk(1, 0, 4'd0,  ST_READY, CMD_NOP, 0, 1, 0, 1, S_IDLE));
        vt.push_back(mk(1, 1, 4'd15, ST_READY, CMD_NOP, 1, 1, 0, 1, S_IDLE));
        vt.push_back(mk(1, 0, 4'd0,  ST_READY, 4'd15,   0, 1, 0, 2, S_ISSUE));
        for (int i = 0; i < AT; i++)
            vt.push_back(mk(1, 0, 4'd0, ST_READY, CMD_NOP, 0, 1, 0, 2, S_WAIT_ACK));
        vt.push_back(mk(1, 0, 4'd0,  ST_READY, CMD_NOP, 0, 1, 0, 2, S_IDLE));
        vt.push_back(mk(1, 1, 4'd12, ST_READY, CMD_NOP, 1, 1, 0, 2, S_IDLE));
        vt.push_back(mk(1, 1, 4'd9,  ST_READY, 4'd12,   1, 1, 0, 3, S_ISSUE));

        for (int i = 0; i < vt.size(); i++) begin
            cyc(vt[i].rst, vt[i].kv, vt[i].kc, vt[i].st);
            check($sformatf("v%0d_cmd", i),       int'(cmd),       int'(vt[i].e_cmd));
            check($sformatf("v%0d_level", i),     int'(level),     vt[i].e_lvl);
            check($sformatf("v%0d_key_ready", i), int'(key_ready), int'(vt[i].e_kr));
            check($sformatf("v%0d_error", i),     int'(error),     int'(vt[i].e_err));
            check($sformatf("v%0d_issued", i),    int'(issued),    vt[i].e_iss);
            check($sformatf("v%0d_state", i),     int'(dut.state), int'(vt[i].e_st));
        end

        // Back-pressure: busy core, fifth key refused, then drained in order.
        cyc(0, 0, 4'd0, ST_BUSY);
        for (int i = 1; i <= 4; i++) cyc(1, 1, 4'(i), ST_BUSY);
        check("bp_level_full", int'(level), 4);
        check("bp_key_ready", int'(key_ready), 0);
        cyc(1, 1, 4'd5, ST_BUSY);
        check("bp_level_after_fifth", int'(level), 4);
        got.delete();
        for (int i = 0; i < 40; i++) begin
            cyc(1, 0, 4'd0, ST_READY);
            if (cmd != CMD_NOP) got.push_back(int'(cmd));
        end
        check("bp_issue_count", got.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("bp_order%0d", i), (i < got.size()) ? got[i] : -1, i + 1);

        // Error during WAIT_DONE with three keys queued, then reset recovery.
        cyc(0, 0, 4'd0, ST_READY);
        cyc(1, 1, 4'd1, ST_READY);
        cyc(1, 1, 4'd2, ST_READY);
        cyc(1, 1, 4'd3, ST_BUSY);
        cyc(1, 1, 4'd4, ST_BUSY);
        check("err_pre_state", int'(dut.state), int'(S_WAIT_DONE));
        check("err_pre_level", int'(level), 3);
        cyc(1, 0, 4'd0, ST_ERR);
        check("err_error", int'(error), 1);
        check("err_level", int'(level), 0);
        check("err_cmd", int'(cmd), int'(CMD_NOP));
        check("err_key_ready", int'(key_ready), 0);
        check("err_state", int'(dut.state), int'(S_ERR));
        for (int i = 0; i < 3; i++) cyc(1, 1, 4'd6, ST_READY);
        check("err_push_ignored", int'(level), 0);
        check("err_issued_hold", int'(issued), 1);
        check("err_sticky", int'(error), 1);
        cyc(0, 0, 4'd0, ST_READY);
        check("rst_cmd", int'(cmd), int'(CMD_NOP));
        check("rst_error", int'(error), 0);
        check("rst_level", int'(level), 0);
        check("rst_key_ready", int'(key_ready), 1);
        check("rst_issued", int'(issued), 0);
        check("rst_state", int'(dut.state), int'(S_IDLE));

        // Counter wrap with a core that goes busy briefly after each command.
        n_iss  = 0;
        busy_n = 0;
        for (int i = 0; i < 4000 && n_iss < 256; i++) begin
            cyc(1, 1, 4'($urandom_range(0, 12)), (busy_n > 0) ? ST_BUSY : ST_READY);
            if (busy_n > 0) busy_n--;
            if (cmd != CMD_NOP) begin
                n_iss++;
                busy_n = 2;
            end
        end
        check("wrap_issue_count", n_iss, 256);
        check("wrap_issued_zero", int'(issued), 0);

        // Randomized traffic including occasional errors and resets.
        cyc(0, 0, 4'd0, ST_READY);
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 149) != 0);
            r_kv  = ($urandom_range(0, 2) != 0);
            r_sel = $urandom_range(0, 199);
            r_st  = (r_sel < 1) ? ST_ERR : (r_sel < 80) ? ST_BUSY :
                    (r_sel < 110) ? ST_PRINT : ST_READY;
            cyc(r_rst, r_kv, 4'($urandom_range(0, 15)), r_st);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_cmd_sched.md
# calc_cmd_sched

Command scheduler placed between the keypad decoder and the calculator core. It buffers keypad codes in a small FIFO and issues them to the calculator's 4-bit `cmd` input one at a time. A command is released only when the calculator reports READY, and issue then waits for the core to accept and finish it before releasing the next. A calculator ERROR status latches a sticky error and flushes pending keys until reset.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `ACK_TIMEOUT`, 4: cycles to wait for the core to leave READY after an issue before treating the command as silently absorbed; at least 1.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: reset is synchronous and active-low.
- `key_valid` in 1: keypad code valid.
- `key_code` in 4: 0–9 digit, 10 `+`, 11 `-`, 12 `x`, 13 no-op, 14 `=`, 15 backspace.
- `key_ready` out 1: FIFO not full and not in ERR.
- `calc_status` in 2: core status; 00 error, 01 busy, 10 ready, 11 printing.
- `cmd` out 4: registered command to the core; 13 (no-op) when not issuing.
- `error` out 1: sticky, set on status 00.
- `level` out `$clog2(DEPTH+1)`: FIFO occupancy.
- `issued` out 8: count of commands issued; wraps 255→0.

## Operation
- Push when `key_valid && key_ready`. `key_code` 13 is accepted and stored like any other code.
- FSM states:
  - **IDLE**
    - `cmd` is 13.
    - If `level>0 && calc_status==10`: pop head, `cmd<=head`, `issued<=issued+1`, go ISSUE.
  - **ISSUE**
    - Lasts exactly 1 cycle with `cmd`=head.
    - Next edge: `cmd<=13`, timer cleared, go WAIT_ACK.
  - **WAIT_ACK**
    - `calc_status!=10` → WAIT_DONE.
    - Otherwise, when timer reaches `ACK_TIMEOUT-1` → IDLE.
    - Otherwise the timer increments.
  - **WAIT_DONE**
    - `calc_status==10` → IDLE.
  - **ERR**
    - `cmd`=13, `error`=1, FIFO flushed (`level`=0), `key_ready`=0, pushes ignored.
    - Exit only by reset.
- `calc_status==00` in any non-ERR state → ERR on the next edge. This has priority over every other transition.
- If the ERR transition coincides with a pop, the pop is cancelled and `issued` is not incremented.
- Simultaneous push and pop: both occur and `level` is unchanged. A push while full is impossible because `key_ready`=0.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `level` is a separate counter, saturating at `DEPTH` by construction.

## Timing
- Reset (`reset`=0 at an edge) gives: state IDLE, `cmd`=13, `error`=0, `level`=0, `key_ready`=1, `issued`=0, pointers and timer 0.
- Reset mid-operation discards the FIFO contents and any in-flight command.
- Latency with the core READY: key accepted at edge k → `level`=1 after k → `cmd`=code after edge k+1 → `cmd`=13 after edge k+2.
- Back-to-back issue: the minimum spacing between issued commands is 3 cycles (ISSUE, WAIT_ACK, IDLE). The actual spacing depends on core status.
- Timeout path: a core that stays READY returns the FSM to IDLE `ACK_TIMEOUT` cycles after WAIT_ACK is entered.
- `key_ready` and `level` are combinational from registered state. All other outputs are registered.

## Structure
- Shared package `calc_pkg`:
  - status constants: `ST_ERR`, `ST_BUSY`, `ST_READY`, `ST_PRINT`
  - command constants: `CMD_ADD`, `CMD_SUB`, `CMD_MUL`, `CMD_NOP`, `CMD_EQ`, `CMD_BKSP`
  - the scheduler state enum
- One sub-module, `cmd_fifo`: a parameterised synchronous FIFO with push, pop, flush, full, empty and level.
- The FSM, timer and `issued` counter sit in the top level.

## Test plan
- **Single key:**
  - Stimulus: after reset, core at 10, push 7.
  - Response: `cmd`=7 for exactly one cycle two cycles after the push, then 13, and `issued`=1.
  - Stimulus: core goes 11 for 9 cycles, then 10.
  - Response: FSM returns to IDLE.
- **Back-pressure:**
  - Stimulus: core held at 01, push 5 keys with `DEPTH`=4.
  - Response: the 5th key is refused (`key_ready`=0) and `level`=4.
  - Stimulus: release the core to 10.
  - Response: the four codes are issued in order.
- **Timeout:**
  - Stimulus: core held at 10 constantly, push 15.
  - Response: after the issue, the FSM spends 4 cycles in WAIT_ACK, then IDLE.
- **Error:**
  - Stimulus: 3 keys queued, core drives 00 during WAIT_DONE.
  - Response: `error`=1, `level`=0, `cmd`=13, further pushes ignored.
  - Stimulus: `reset`=0 for one edge.
  - Response: all outputs return to their reset values.
- **Simultaneous push/pop:**
  - Stimulus: `level`=1 and core at 10, push 12 on the same edge as the pop.
  - Response: `level` stays 1.
- **Counter wrap:**
  - Stimulus: 256 issues with a fast-acking core model.
  - Response: `issued` wraps to 0.
